key_debounce_lp: RTL

- Multi-channel push-button conditioner for active-low keys.
- Each channel has its own debounce counter, so channels settle independently.
- Each channel emits a press pulse, a release pulse, a long-press pulse and periodic auto-repeat pulses.
- Sits between board key pins and user logic (menus, counters, mode selectors).

---
 rtl/key_debounce_lp.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/key_debounce_lp.sv
// key_debounce_lp: per-channel conditioner for active-low push buttons.
// The raw input is synchronised and debounced. Each channel then produces
// press, release, long-press and auto-repeat pulses, plus a hold level.
// Latency: key_stable follows key_n after DEB_CNT+3 edges; pulses follow 1 cycle later.
// Backpressure: none; every output is a free-running level or a 1-cycle pulse.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   key_n        raw keys, 0 = pressed, asynchronous to clk
//   key_stable   debounced level, active-low
//   key_press    1-cycle pulse on a debounced press
//   key_release  1-cycle pulse on a debounced release
//   key_long     1-cycle pulse when a press has lasted LONG_CNT cycles
//   key_repeat   1-cycle pulse every REP_CNT cycles after key_long
//   key_hold     high while the channel is in long-hold
module key_debounce_lp #(
  parameter int KEY_WIDTH = 4,
  parameter int DEB_CNT   = 240000,
  parameter int LONG_CNT  = 12000000,
  parameter int REP_CNT   = 2400000,
  parameter int CNT_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic [KEY_WIDTH-1:0] key_stable,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release,
  output logic [KEY_WIDTH-1:0] key_long,
  output logic [KEY_WIDTH-1:0] key_repeat,
  output logic [KEY_WIDTH-1:0] key_hold
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REP_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // s1/s2 form the synchroniser; s3 is the previous s2, so that any input
  // movement restarts the debounce count.
  logic [KEY_WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_ch
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] deb_cnt;
    logic             fall, rise;
    state_t           state, state_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic             press_q, release_q, long_q, repeat_q;
    logic             press_nx, release_nx, long_nx, repeat_nx;

    // Debounce: count only while the synchronised level is steady and
    // differs from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= 1'b1;
        stable_d <= 1'b1;
        deb_cnt  <= '0;
      end else begin
        stable_d <= stable_q;
        if ((s2[i] == stable_q) || (s2[i] != s3[i])) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
          stable_q <= s2[i];
          deb_cnt  <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_ONE;
        end
      end
    end

    assign fall = stable_d & ~stable_q;
    assign rise = ~stable_d & stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_nx;
        hold_cnt  <= hold_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
        repeat_q  <= repeat_nx;
      end
    end

    // A release is tested before the long/repeat thresholds so that it
    // suppresses a threshold pulse falling in the same cycle.
    always_comb begin
      state_nx   = state;
      hold_nx    = hold_cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            press_nx = 1'b1;
            hold_nx  = '0;
            state_nx = PRESSED;
          end
        end
        PRESSED: begin
          if (rise) begin
            release_nx = 1'b1;
            hold_nx    = '0;
            state_nx   = IDLE;
          end else if (hold_cnt == LONG_MAX) begin
            long_nx  = 1'b1;
            hold_nx  = '0;
            state_nx = LONG;
          end else begin
            hold_nx = hold_cnt + CNT_ONE;
          end
        end
        LONG: begin
          if (rise) begin
            release_nx = 1'b1;
            hold_nx    = '0;
            state_nx   = IDLE;
          end else if (hold_cnt == REP_MAX) begin
            repeat_nx = 1'b1;
            hold_nx   = '0;
          end else begin
            hold_nx = hold_cnt + CNT_ONE;
          end
        end
        default: begin
          hold_nx  = '0;
          state_nx = IDLE;
        end
      endcase
    end

    assign key_stable[i]  = stable_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
    assign key_hold[i]    = (state == LONG);
  end

endmodule
